// File: rtl/im_access_arbiter_pkg.sv
// Shared types and constants for the instruction-memory access arbiter.
// Optional feature macro used by the arbiter: IM_ARB_PERF_EN.
package im_access_arbiter_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    localparam int IM_DATA_BYTES = 4;
    localparam int RNG_32        = 32;
    localparam int RNG_64        = 64;
    localparam logic [RNG_64-1:0] BOOT_PC = 64'h0000_0000_0000_0100;

endpackage

// File: rtl/im_arb_starve_ctr.sv
// Counts consecutive fetch wins while a load write waits; flags when the load must be let through.
module im_arb_starve_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic fetch_win_i,
    input  logic load_gnt_i,
    input  logic load_req_i,
    output logic at_max_o
);

    localparam int CW = 4;

    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (load_gnt_i || !load_req_i) begin
            wait_cnt_d = '0;
        end else if (fetch_win_i) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign at_max_o = (wait_cnt_q == CW'(MAX_WAIT));

endmodule

// File: rtl/im_access_arbiter.sv
// Shares the single instruction-memory port between fetch reads and loader writes (boot, then run).
// Read data returns 1 cycle after grant; IM_ARB_PERF_EN adds stall/flush counters.
module im_access_arbiter
    import im_access_arbiter_pkg::*;
#(
    parameter int AW       = 11,
    parameter int MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_fetch_req,
    input  logic [RNG_64-1:0]        i_fetch_addr,
    input  logic                     i_fetch_flush,
    output logic                     o_fetch_gnt,
    output logic                     o_fetch_rvalid,
    output logic [RNG_32-1:0]        o_fetch_rdata,
    input  logic                     i_load_req,
    input  logic [AW-1:0]            i_load_addr,
    input  logic [IM_DATA_BYTES-1:0] i_load_be,
    input  logic [RNG_32-1:0]        i_load_wdata,
    input  logic                     i_load_done,
    output logic                     o_load_gnt,
    output logic [AW-1:0]            o_im_addr,
    output logic [IM_DATA_BYTES-1:0] o_im_wen,
    output logic [RNG_32-1:0]        o_im_wdata,
    input  logic [RNG_32-1:0]        i_im_rdata,
`ifdef IM_ARB_PERF_EN
    output logic [RNG_32-1:0]        o_fetch_stall_cnt,
    output logic [RNG_32-1:0]        o_flush_cnt,
`endif
    output logic                     o_boot
);

    arb_state_e state_q, state_d;
    logic       rd_pend_q, rd_pend_d;
    logic       fetch_gnt, load_gnt, starve;
    logic       unused_addr_hi;

    assign unused_addr_hi = ^i_fetch_addr[RNG_64-1:AW];

    im_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk         (clk),
        .rst         (rst),
        .fetch_win_i (fetch_gnt),
        .load_gnt_i  (load_gnt),
        .load_req_i  (i_load_req),
        .at_max_o    (starve)
    );

    // Grants are held low during reset so the port is quiet before state is known.
    always_comb begin
        fetch_gnt  = 1'b0;
        load_gnt   = 1'b0;
        o_im_addr  = '0;
        o_im_wen   = '0;
        o_im_wdata = '0;
        if (!rst) begin
            if (state_q == BOOT) begin
                load_gnt = i_load_req;
            end else if (i_fetch_req && !(i_load_req && starve)) begin
                fetch_gnt = 1'b1;
            end else begin
                load_gnt = i_load_req;
            end
        end
        if (fetch_gnt) begin
            o_im_addr = i_fetch_addr[AW-1:0];
        end else if (load_gnt) begin
            o_im_addr  = i_load_addr;
            o_im_wen   = i_load_be;
            o_im_wdata = i_load_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_pend_d = fetch_gnt & ~i_fetch_flush;
        if (state_q == BOOT && i_load_done) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BOOT;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign o_fetch_gnt    = fetch_gnt;
    assign o_load_gnt     = load_gnt;
    assign o_fetch_rvalid = rd_pend_q & ~i_fetch_flush & ~rst;
    assign o_fetch_rdata  = i_im_rdata;
    assign o_boot         = rst | (state_q == BOOT);

`ifdef IM_ARB_PERF_EN
    logic [RNG_32-1:0] stall_cnt_q, stall_cnt_d;
    logic [RNG_32-1:0] flush_cnt_q, flush_cnt_d;
    logic [1:0]        kill_n;

    // A flush can kill both the response in flight and the grant issued this cycle.
    always_comb begin
        kill_n      = {1'b0, fetch_gnt & i_fetch_flush} + {1'b0, rd_pend_q & i_fetch_flush};
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == RUN && i_fetch_req && !fetch_gnt && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_cnt_q > ('1 - RNG_32'(kill_n))) begin
            flush_cnt_d = '1;
        end else begin
            flush_cnt_d = flush_cnt_q + RNG_32'(kill_n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_fetch_stall_cnt = stall_cnt_q;
    assign o_flush_cnt       = flush_cnt_q;
`endif

endmodule

// File: tb/tb_im_access_arbiter.sv
// Randomized and directed check of im_access_arbiter against a behavioural model with its own memory image.
module tb_im_access_arbiter;

    localparam int AW       = 11;
    localparam int MAX_WAIT = 4;
    localparam int WORDS    = 1 << (AW - 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          i_fetch_req, i_fetch_flush, i_load_req, i_load_done;
    logic [63:0]   i_fetch_addr;
    logic [AW-1:0] i_load_addr;
    logic [3:0]    i_load_be;
    logic [31:0]   i_load_wdata;
    logic          o_fetch_gnt, o_fetch_rvalid, o_load_gnt, o_boot;
    logic [31:0]   o_fetch_rdata, o_im_wdata;
    logic [AW-1:0] o_im_addr;
    logic [3:0]    o_im_wen;
    logic [31:0]   i_im_rdata = '0;
`ifdef IM_ARB_PERF_EN
    logic [31:0]   o_fetch_stall_cnt, o_flush_cnt;
`endif

    im_access_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr), .i_fetch_flush(i_fetch_flush),
        .o_fetch_gnt(o_fetch_gnt), .o_fetch_rvalid(o_fetch_rvalid), .o_fetch_rdata(o_fetch_rdata),
        .i_load_req(i_load_req), .i_load_addr(i_load_addr), .i_load_be(i_load_be),
        .i_load_wdata(i_load_wdata), .i_load_done(i_load_done), .o_load_gnt(o_load_gnt),
        .o_im_addr(o_im_addr), .o_im_wen(o_im_wen), .o_im_wdata(o_im_wdata),
        .i_im_rdata(i_im_rdata),
`ifdef IM_ARB_PERF_EN
        .o_fetch_stall_cnt(o_fetch_stall_cnt), .o_flush_cnt(o_flush_cnt),
`endif
        .o_boot(o_boot)
    );

    always #5 clk = ~clk;

    // Memory behind the port: registered read, byte-enabled write.
    logic [31:0] bmem [0:WORDS-1];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (o_im_wen[b]) bmem[o_im_addr[AW-1:2]][b*8 +: 8] <= o_im_wdata[b*8 +: 8];
        end
        i_im_rdata <= bmem[o_im_addr[AW-1:2]];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model
    logic [31:0] shadow [0:WORDS-1];
    bit          m_boot = 1'b1;
    int          m_streak = 0;
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_data = '0;

    bit          last_fg, last_lg, last_rv, last_boot;
    logic [31:0] last_rd;

    task automatic step(input bit fr, input logic [63:0] fa, input bit ff, input bit lr,
                        input logic [AW-1:0] la, input logic [3:0] be, input logic [31:0] wd,
                        input bit ld, input bit r);
        bit e_fg, e_lg, e_rv;
        logic [AW-1:0] e_addr;
        i_fetch_req = fr; i_fetch_addr = fa; i_fetch_flush = ff;
        i_load_req = lr; i_load_addr = la; i_load_be = be; i_load_wdata = wd;
        i_load_done = ld; rst = r;
        #2;
        e_fg = 1'b0; e_lg = 1'b0;
        if (!r) begin
            if (m_boot)                                  e_lg = lr;
            else if (lr && m_streak >= MAX_WAIT)         e_lg = 1'b1;
            else if (fr)                                 e_fg = 1'b1;
            else                                         e_lg = lr;
        end
        e_rv   = m_pend && !ff && !r;
        e_addr = e_fg ? fa[AW-1:0] : (e_lg ? la : '0);
        chk("fetch_gnt", 64'(o_fetch_gnt), 64'(e_fg));
        chk("load_gnt", 64'(o_load_gnt), 64'(e_lg));
        chk("im_addr", 64'(o_im_addr), 64'(e_addr));
        chk("im_wen", 64'(o_im_wen), 64'(e_lg ? be : 4'h0));
        if (e_lg) chk("im_wdata", 64'(o_im_wdata), 64'(wd));
        chk("rvalid", 64'(o_fetch_rvalid), 64'(e_rv));
        if (e_rv) chk("rdata", 64'(o_fetch_rdata), 64'(m_pend_data));
        chk("boot", 64'(o_boot), 64'(m_boot || r));
        last_fg = o_fetch_gnt; last_lg = o_load_gnt; last_rv = o_fetch_rvalid;
        last_rd = o_fetch_rdata; last_boot = o_boot;
        if (r) begin
            m_boot = 1'b1; m_streak = 0; m_pend = 1'b0;
        end else begin
            if (e_fg) m_pend_data = shadow[fa[AW-1:2]];
            m_pend = e_fg && !ff;
            if (e_lg) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) shadow[la[AW-1:2]][b*8 +: 8] = wd[b*8 +: 8];
            end
            if (lr && e_fg) m_streak++;
            else            m_streak = 0;
            if (m_boot && ld) m_boot = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit r);
        step(0, 64'h0, 0, 0, '0, 4'h0, 32'h0, 0, r);
    endtask

    initial begin
        int n_lg;
        logic [9:0] pat;
        for (int i = 0; i < WORDS; i++) begin
            bmem[i]   = '0;
            shadow[i] = '0;
        end
        #1;
        idle(1);
        idle(1);

        // Boot loads with fetch already requesting
        n_lg = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 64'h100, 0, 1, AW'(32'h100 + 4 * i), 4'hF, 32'h1111_0000 + i, 0, 0);
            n_lg += int'(last_lg);
        end
        chk("boot_load_cnt", 64'(n_lg), 64'd3);
        step(1, 64'h100, 0, 0, '0, 4'h0, 32'h0, 1, 0);
        chk("boot_fetch_blocked", 64'(last_fg), 64'd0);
        step(1, 64'h100, 0, 0, '0, 4'h0, 32'h0, 0, 0);
        chk("boot_fall", 64'(last_boot), 64'd0);
        chk("first_run_gnt", 64'(last_fg), 64'd1);
        idle(0);
        chk("first_rvalid", 64'(last_rv), 64'd1);
        chk("first_rdata", 64'(last_rd), 64'h1111_0000);

        // Flush on the grant cycle, then flush on the response cycle
        step(1, 64'h100, 1, 0, '0, 4'h0, 32'h0, 0, 0);
        idle(0);
        chk("flush_same", 64'(last_rv), 64'd0);
        step(1, 64'h104, 0, 0, '0, 4'h0, 32'h0, 0, 0);
        step(0, 64'h0, 1, 0, '0, 4'h0, 32'h0, 0, 0);
        chk("flush_late", 64'(last_rv), 64'd0);

        // Partial-byte write then readback
        step(0, 64'h0, 0, 1, AW'(32'h200), 4'h3, 32'hDEAD_BEEF, 0, 0);
        step(1, 64'h200, 0, 0, '0, 4'h0, 32'h0, 0, 0);
        idle(0);
        chk("readback", 64'(last_rd), 64'h0000_BEEF);

        // Starvation pattern with a zero-byte-enable load
        for (int i = 0; i < 10; i++) begin
            step(1, 64'h100, 0, 1, AW'(32'h300), 4'h0, 32'hFFFF_FFFF, 0, 0);
            pat[i] = last_lg;
        end
        chk("starve_pattern", 64'(pat), 64'h210);
        idle(0);

        // Reset the cycle after a fetch grant
        step(1, 64'h108, 0, 0, '0, 4'h0, 32'h0, 0, 0);
        idle(1);
        chk("rst_kills_rvalid", 64'(last_rv), 64'd0);
        idle(0);
        chk("rst_boot", 64'(last_boot), 64'd1);
        chk("rst_no_rvalid", 64'(last_rv), 64'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 3) != 0),
                 {$urandom(), $urandom()},
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 1) == 1),
                 AW'($urandom()),
                 4'($urandom()),
                 $urandom(),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 99) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
